// File: rtl/add_pkg.sv
// Shared types for the add request/response service.
// State encoding, default width and the packed {carry, sum} result.
package add_pkg;

  localparam int ADD_WIDTH = 4;
  localparam int ADD_LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } add_state_e;

  typedef struct packed {
    logic                 carry;
    logic [ADD_WIDTH-1:0] sum;
  } add_res_t;

endpackage

// File: rtl/add_responder_if.sv
// Request/response handshake bundle between an add initiator
// (master) and the add responder (slave).
interface add_responder_if
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_carry;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_sum,
    input  rsp_carry
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_sum,
    output rsp_carry
  );

endinterface

// File: rtl/add_lat_counter.sv
// Loadable down-counter with a zero flag; holds at zero.
module add_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/add_responder.sv
// Clocked, back-pressurable 4-bit add service (IDLE/COMPUTE/RESP).
// Define ADD_RESPONDER_SAT_EN to saturate the sum on carry-out.
module add_responder
  import add_pkg::*;
#(
  parameter int WIDTH   = ADD_WIDTH,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  add_responder_if.slave   bus,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int LAT_W = ADD_LAT_W;

  add_state_e       state_q;
  add_state_e       state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   res_q;
  logic [WIDTH:0]   res_d;
  logic [WIDTH:0]   sum_full;
  logic [CNT_W-1:0] done_q;

  logic capture;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic res_we;
  logic done_inc;

  add_lat_counter #(
    .W (LAT_W)
  ) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_W'(LATENCY - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    res_we   = 1'b0;
    done_inc = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.req_valid) begin
          capture  = 1'b1;
          cnt_load = 1'b1;
          state_d  = COMPUTE;
        end
      end
      (state_q == COMPUTE): begin
        if (cnt_zero) begin
          res_we  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      (state_q == RESP): begin
        if (bus.rsp_ready) begin
          done_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sum_full = {1'b0, a_q} + {1'b0, b_q};

`ifdef ADD_RESPONDER_SAT_EN
  // Carry still reported so the consumer can tell a clamp from a real 1111.
  assign res_d = sum_full[WIDTH] ? {1'b1, {WIDTH{1'b1}}}
                                 : sum_full;
`else
  assign res_d = sum_full;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      done_q <= '0;
    end else begin
      if (capture) begin
        a_q <= bus.req_a;
        b_q <= bus.req_b;
      end
      if (res_we) begin
        res_q <= res_d;
      end
      if (done_inc) begin
        done_q <= done_q + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_sum   = res_q[WIDTH-1:0];
  assign bus.rsp_carry = res_q[WIDTH];
  assign busy          = (state_q != IDLE);
  assign done_cnt      = done_q;

endmodule

// File: doc/add_responder.md
Name: add_responder

Overview:
- Responder end of the 4-bit add request interface.
- Accepts one operand pair (a, b) per transaction over a valid/ready request channel.
- Computes the sum over a fixed, parameterised number of cycles.
- Returns the sum and carry over a valid/ready response channel.
- Sits between any add initiator (task-driven bench or RTL master) and the consumer of results.
- Replaces the in-module blocking add with a clocked, back-pressurable service.

Parameters:
- WIDTH, 4, operand and sum width in bits.
- LATENCY, 2, cycles from request acceptance to rsp_valid assertion; legal range 1..15.
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  initiator presents operands.
- req_ready  output  1  responder can accept a request.
- req_a  input  WIDTH  operand a.
- req_b  input  WIDTH  operand b.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_sum  output  WIDTH  a+b, low WIDTH bits (or saturated, see Optional Feature).
- rsp_carry  output  1  carry out of a+b.
- busy  output  1  high in any state other than IDLE.
- done_cnt  output  CNT_W  count of completed response handshakes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_sum = 0, rsp_carry = 0, busy = 0, done_cnt = 0.
  - Latency counter = 0; captured operands = 0.
  - Reset overrides every other input on that edge, including mid-COMPUTE and mid-RESP; any pending result is discarded without a handshake.
- FSM states: IDLE, COMPUTE, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: capture req_a/req_b, load latency counter with LATENCY-1, go to COMPUTE.
- COMPUTE:
  - req_ready = 0; requests are ignored and not captured.
  - Counter decrements each cycle.
  - When the counter is 0: register {carry, sum} = a + b (WIDTH+1-bit add, zero-extended), set rsp_valid = 1, go to RESP.
  - Result: a request accepted at edge N produces rsp_valid high after edge N+LATENCY.
- RESP:
  - rsp_valid = 1; rsp_sum and rsp_carry stay stable while rsp_ready = 0, for unbounded stall.
  - On rsp_ready: clear rsp_valid, increment done_cnt, go to IDLE.
  - No back-to-back overlap: req_ready returns high on the cycle after the response handshake. A request held on req_valid throughout is accepted on that cycle.
  - Steady-state throughput with rsp_ready tied high: one transaction per LATENCY+2 cycles.
- Arithmetic:
  - Wrap-around modulo 2^WIDTH; rsp_carry = bit WIDTH of the full sum.
  - rsp_sum/rsp_carry retain their last value after the handshake until the next result is written.
- done_cnt wraps from 2^CNT_W-1 to 0 silently.
- req_valid may drop without a handshake; the responder must not capture it. No req_valid stability assertion is required.
- rsp_ready arriving while rsp_valid = 0 has no effect.

Optional Feature:
- Macro: ADD_RESPONDER_SAT_EN.
- Defined:
  - On carry, rsp_sum = all ones (4'b1111 at default WIDTH).
  - rsp_carry is still reported as 1.
  - Non-overflowing results are unchanged.
- Undefined: wrap-around sum as above.
- Interface and timing are identical in both builds.

Decomposition:
- Package add_pkg holds:
  - state enum typedef (IDLE, COMPUTE, RESP), 2-bit encoding.
  - default WIDTH localparam.
  - typedef for the packed {carry, sum} result.
- Optional sub-module add_lat_counter: loadable down-counter with zero flag, parameterised by counter width.
- Everything else stays in one module.

Test Plan:
- Reset, then req a=5, b=6 with rsp_ready=1 -> rsp_valid exactly 2 cycles after acceptance, rsp_sum=4'b1011, rsp_carry=0, done_cnt=1.
- a=9, b=8 -> rsp_sum=4'b0001, rsp_carry=1; with ADD_RESPONDER_SAT_EN -> rsp_sum=4'b1111, rsp_carry=1.
- a=2, b=3, hold rsp_ready=0 for 6 cycles -> rsp_valid stays 1 and rsp_sum=4'b0101 stays stable; req_ready=0 throughout. Release -> one handshake, done_cnt increments once.
- req_valid held high with alternating operands (1,1), (15,15) while the responder is in COMPUTE -> second pair accepted only after the first response handshake. Results 4'b0010/c0, then 4'b1110/c1 (4'b1111/c1 with sat).
- Assert rst during COMPUTE and again during RESP -> next cycle rsp_valid=0, req_ready=1, busy=0, done_cnt=0; no stale result is ever presented.
- 256 back-to-back transactions with rsp_ready=1 -> done_cnt wraps to 0; each transaction spans LATENCY+2 cycles.
